urisc_mem: RTL

Parametrised unified instruction/data memory for the URISC core. It replaces the fixed 128x8 hard-reset RAM with a memory of configurable width and depth. After reset it clears itself sequentially, and a boot-load port lets the testbench or host download a program before the core runs. CPU reads are registered with a valid strobe, out-of-range accesses are flagged, and two parametrised probe taps expose result registers (X, Z) to the bench.

---
 rtl/urisc_mem_if.sv | 31 +++
 rtl/urisc_mem.sv | 121 ++++++++++++
 2 files changed

// File: rtl/urisc_mem_if.sv
// rtl/urisc_mem_if.sv - CPU and boot-load bus for the URISC unified memory.
interface urisc_mem_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic              CS;
    logic              READ;
    logic              WRITE;
    logic [ADDR_W-1:0] ADDRESS;
    logic [DATA_W-1:0] WDATA;
    logic [DATA_W-1:0] RDATA;
    logic              RVALID;
    logic              ERR;
    logic              READY;
    logic              BOOT_EN;
    logic              BOOT_WE;
    logic [ADDR_W-1:0] BOOT_ADDR;
    logic [DATA_W-1:0] BOOT_DATA;

    modport master (
        output CS, READ, WRITE, ADDRESS, WDATA,
        output BOOT_EN, BOOT_WE, BOOT_ADDR, BOOT_DATA,
        input  RDATA, RVALID, ERR, READY
    );

    modport slave (
        input  CS, READ, WRITE, ADDRESS, WDATA,
        input  BOOT_EN, BOOT_WE, BOOT_ADDR, BOOT_DATA,
        output RDATA, RVALID, ERR, READY
    );
endinterface

// File: rtl/urisc_mem.sv
// rtl/urisc_mem.sv - URISC unified memory: self-clearing after reset, boot-load port,
// registered read-first CPU port with range error strobe, and two probe taps.
module urisc_mem #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 128,
    parameter int PROBE0_ADDR = 35,
    parameter int PROBE1_ADDR = 36
) (
    input  logic              clk,
    input  logic              rst_n,
    urisc_mem_if.slave        bus,
    output logic [DATA_W-1:0] probe0,
    output logic [DATA_W-1:0] probe1
);
    localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W+1)'(DEPTH);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q;
    logic [DATA_W-1:0]  mem [DEPTH];

    logic               cpu_ok, cpu_rd, cpu_wr;
    logic               cpu_in_range, boot_in_range;
    logic [IDX_W-1:0]   cpu_idx;
    logic               we;
    logic [IDX_W-1:0]   waddr;
    logic [DATA_W-1:0]  wdata;
    logic [DATA_W-1:0]  rdata_q;
    logic               rvalid_q, err_q;

    assign cpu_in_range  = {1'b0, bus.ADDRESS}   < DEPTH_X;
    assign boot_in_range = {1'b0, bus.BOOT_ADDR} < DEPTH_X;
    assign cpu_idx       = bus.ADDRESS[IDX_W-1:0];

    assign bus.READY = (state_q == RUN) && !bus.BOOT_EN;
    assign cpu_ok    = bus.READY && bus.CS;
    assign cpu_rd    = cpu_ok && bus.READ;
    assign cpu_wr    = cpu_ok && bus.WRITE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == CLEAR) begin
                ptr_q <= ptr_q + 1'b1;
            end
        end
    end

    // Single write port: clear sweep, then boot and CPU are exclusive through BOOT_EN.
    always_comb begin
        state_d = state_q;
        we      = 1'b0;
        waddr   = ptr_q;
        wdata   = '0;
        case (state_q)
            CLEAR: begin
                we = 1'b1;
                if (ptr_q == LAST_IDX) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bus.BOOT_EN) begin
                    if (bus.BOOT_WE && boot_in_range) begin
                        we    = 1'b1;
                        waddr = bus.BOOT_ADDR[IDX_W-1:0];
                        wdata = bus.BOOT_DATA;
                    end
                end else if (cpu_wr && cpu_in_range) begin
                    we    = 1'b1;
                    waddr = cpu_idx;
                    wdata = bus.WDATA;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read-first: the registered read samples mem before this edge's write lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            rvalid_q <= cpu_rd;
            err_q    <= (cpu_rd || cpu_wr) && !cpu_in_range;
            rdata_q  <= (cpu_rd && cpu_in_range) ? mem[cpu_idx] : '0;
        end
    end

    assign bus.RDATA  = rdata_q;
    assign bus.RVALID = rvalid_q;
    assign bus.ERR    = err_q;

    generate
        if (PROBE0_ADDR >= 0 && PROBE0_ADDR < DEPTH) begin : g_probe0
            assign probe0 = (state_q == RUN) ? mem[IDX_W'(PROBE0_ADDR)] : '0;
        end else begin : g_probe0_off
            assign probe0 = '0;
        end
        if (PROBE1_ADDR >= 0 && PROBE1_ADDR < DEPTH) begin : g_probe1
            assign probe1 = (state_q == RUN) ? mem[IDX_W'(PROBE1_ADDR)] : '0;
        end else begin : g_probe1_off
            assign probe1 = '0;
        end
    endgenerate
endmodule
